// File: rtl/if_fetch_unit.sv
// IF-stage PC generator with branch prediction and EX/ID redirect handling.
// Define FETCH_BHT_EN for a trained 2-bit BHT; otherwise static backward-taken prediction.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned BHT_IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_mem_read_data,
    input  logic        EX_stall,
    input  logic        ID_branch,
    input  logic [31:0] ID_jump_target,
    input  logic        EX_branch,
    input  logic        EX_zero,
    input  logic        EX_pred_take,
    input  logic [31:0] EX_pc,
    input  logic [31:0] EX_branch_target,
    output logic [31:0] inst_mem_read_addr,
    output logic        IF_take
);

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] INST_BYTES = 32'd4;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] imm_b;
    logic        is_br;
    logic        pred;
    logic        mispredict;

    // Decode only what prediction needs: opcode and B-type immediate.
    assign is_br = (inst_mem_read_data[6:0] == OPC_BRANCH);
    assign imm_b = {{19{inst_mem_read_data[31]}}, inst_mem_read_data[31], inst_mem_read_data[7],
                    inst_mem_read_data[30:25], inst_mem_read_data[11:8], 1'b0};

    // rs1/rs2/funct3 are not needed for fetch.
    logic unused_inst_bits;
    assign unused_inst_bits = ^inst_mem_read_data[24:12];

`ifdef FETCH_BHT_EN
    localparam int unsigned BHT_ENTRIES = 2 ** BHT_IDX_BITS;

    logic [1:0]              bht [BHT_ENTRIES];
    logic [BHT_IDX_BITS-1:0] pc_idx;
    logic [BHT_IDX_BITS-1:0] ex_idx;

    assign pc_idx = pc[BHT_IDX_BITS+1:2];
    assign ex_idx = EX_pc[BHT_IDX_BITS+1:2];

    // Read is from the registered table, so a same-cycle train is seen only next cycle.
    assign pred = bht[pc_idx][1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (EX_branch) begin
            if (EX_zero && (bht[ex_idx] != 2'b11)) begin
                bht[ex_idx] <= bht[ex_idx] + 2'b01;
            end else if (!EX_zero && (bht[ex_idx] != 2'b00)) begin
                bht[ex_idx] <= bht[ex_idx] - 2'b01;
            end
        end
    end
`else
    // Backward branches (loops) predicted taken, forward not-taken.
    assign pred = imm_b[31];
`endif

    assign IF_take    = is_br & pred;
    assign mispredict = EX_branch & (EX_zero != EX_pred_take);

    // Redirect priority: EX mispredict, stall, ID jump, predicted branch, sequential.
    always_comb begin
        pc_next = pc + INST_BYTES;
        if (mispredict) begin
            pc_next = EX_zero ? EX_branch_target : (EX_pc + INST_BYTES);
        end else if (EX_stall) begin
            pc_next = pc;
        end else if (ID_branch) begin
            pc_next = ID_jump_target;
        end else if (IF_take) begin
            pc_next = pc + imm_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    assign inst_mem_read_addr = pc;

endmodule
